// File: rtl/ps_pkg.sv
// Shared constants for the parallel-to-serial generator: default word width,
// default idle symbol and idle-counter width, plus a saturating increment helper.
package ps_pkg;

  localparam int         DEF_DATA_W   = 8;
  localparam logic [7:0] DEF_IDLE_SYM = 8'hBC;
  localparam int         IDLE_CNT_W   = 16;

  function automatic logic [IDLE_CNT_W-1:0] sat_inc(input logic [IDLE_CNT_W-1:0] value);
    return (&value) ? value : value + IDLE_CNT_W'(1);
  endfunction

endpackage

// File: rtl/par_serial_gen_if.sv
// Parallel word handshake between a word source (master) and the serializer (slave).
interface par_serial_gen_if
  import ps_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              valid_in_PS;
  logic [DATA_W-1:0] data_in_PS;
  logic              ready_out_PS;

  modport master (
    output valid_in_PS,
    output data_in_PS,
    input  ready_out_PS
  );

  modport slave (
    input  valid_in_PS,
    input  data_in_PS,
    output ready_out_PS
  );

endinterface

// File: rtl/ps_hold_reg.sv
// One-entry hold buffer for accepted parallel words, with the ready/transfer logic.
module ps_hold_reg
  import ps_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              load_edge,
  input  logic              word_valid,
  input  logic [DATA_W-1:0] word_data,
  output logic              word_ready,
  output logic              word_xfer,
  output logic              buf_full,
  output logic [DATA_W-1:0] buf_data
);

  logic              full_reg;
  logic              full_next;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] data_next;

  // A load edge always frees the slot, so a word can be taken even when full.
  assign word_ready = !reset && (!full_reg || load_edge);
  assign word_xfer  = word_valid && word_ready;
  assign buf_full   = full_reg;
  assign buf_data   = data_reg;

  always_comb begin
    full_next = full_reg;
    data_next = data_reg;
    if (load_edge) begin
      // Held word drains to the shifter; an empty buffer lets the new word bypass.
      full_next = full_reg && word_xfer;
      if (full_reg && word_xfer) begin
        data_next = word_data;
      end
    end else if (word_xfer) begin
      full_next = 1'b1;
      data_next = word_data;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      full_reg <= 1'b0;
      data_reg <= '0;
    end else begin
      full_reg <= full_next;
      data_reg <= data_next;
    end
  end

endmodule

// File: rtl/par_serial_gen.sv
// Parallel-to-serial generator, MSB first, idle word fill when no data is held.
// Optional PS_IDLE_CNT_EN adds a saturating count of idle words sent (idle_count_PS).
module par_serial_gen
  import ps_pkg::*;
#(
  parameter int              DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] IDLE_WORD = DATA_W'(DEF_IDLE_SYM)
) (
  input  logic                  clk_32f,
  input  logic                  reset,
  par_serial_gen_if.slave       ps_bus,
  output logic                  data_out_PS,
  output logic                  word_start_PS,
  output logic                  idle_out_PS
`ifdef PS_IDLE_CNT_EN
  ,
  output logic [IDLE_CNT_W-1:0] idle_count_PS
`endif
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0]  cnt_reg;
  logic              first_reg;
  logic              load_edge;
  logic [DATA_W-1:0] shift_reg;
  logic              data_out_reg;
  logic              word_start_reg;
  logic              idle_out_reg;

  logic              word_ready;
  logic              word_xfer;
  logic              buf_full;
  logic [DATA_W-1:0] buf_data;
  logic [DATA_W-1:0] load_word;
  logic              sel_idle;

  // first_reg makes the first edge out of reset a load edge regardless of counter.
  assign load_edge = first_reg || (cnt_reg == CNT_LAST);

  ps_hold_reg #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .load_edge  (load_edge),
    .word_valid (ps_bus.valid_in_PS),
    .word_data  (ps_bus.data_in_PS),
    .word_ready (word_ready),
    .word_xfer  (word_xfer),
    .buf_full   (buf_full),
    .buf_data   (buf_data)
  );

  assign ps_bus.ready_out_PS = word_ready;

  always_comb begin
    load_word = IDLE_WORD;
    sel_idle  = 1'b1;
    if (buf_full) begin
      load_word = buf_data;
      sel_idle  = 1'b0;
    end else if (word_xfer) begin
      load_word = ps_bus.data_in_PS;
      sel_idle  = 1'b0;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      cnt_reg        <= '0;
      first_reg      <= 1'b1;
      shift_reg      <= '0;
      data_out_reg   <= 1'b0;
      word_start_reg <= 1'b0;
      idle_out_reg   <= 1'b0;
    end else if (load_edge) begin
      // MSB goes straight to the output register; the rest waits in the shifter.
      cnt_reg        <= '0;
      first_reg      <= 1'b0;
      data_out_reg   <= load_word[DATA_W-1];
      shift_reg      <= {load_word[DATA_W-2:0], 1'b0};
      word_start_reg <= 1'b1;
      idle_out_reg   <= sel_idle;
    end else begin
      cnt_reg        <= cnt_reg + CNT_W'(1);
      data_out_reg   <= shift_reg[DATA_W-1];
      shift_reg      <= {shift_reg[DATA_W-2:0], 1'b0};
      word_start_reg <= 1'b0;
    end
  end

  assign data_out_PS   = data_out_reg;
  assign word_start_PS = word_start_reg;
  assign idle_out_PS   = idle_out_reg;

`ifdef PS_IDLE_CNT_EN
  logic [IDLE_CNT_W-1:0] idle_cnt_reg;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      idle_cnt_reg <= '0;
    end else if (load_edge && sel_idle) begin
      idle_cnt_reg <= sat_inc(idle_cnt_reg);
    end
  end

  assign idle_count_PS = idle_cnt_reg;
`endif

endmodule

// File: tb/tb_par_serial_gen.sv
// Scoreboard bench: an 8-bit instance driven with idle, bypass, back-to-back,
// mid-word reset and random traffic, plus a 10-bit idle-only instance.
module tb_par_serial_gen;
  import ps_pkg::*;

  localparam int W = 8;

  logic clk_32f = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_32f = ~clk_32f;

  par_serial_gen_if #(.DATA_W(W))  bus ();
  par_serial_gen_if #(.DATA_W(10)) bus10 ();

  logic data_out, word_start, idle_out;
  logic data_out10, word_start10, idle_out10;
`ifdef PS_IDLE_CNT_EN
  logic [15:0] idle_cnt, idle_cnt10;
`endif

  par_serial_gen #(.DATA_W(W)) u_dut (
    .clk_32f       (clk_32f),
    .reset         (reset),
    .ps_bus        (bus),
    .data_out_PS   (data_out),
    .word_start_PS (word_start),
    .idle_out_PS   (idle_out)
`ifdef PS_IDLE_CNT_EN
    ,
    .idle_count_PS (idle_cnt)
`endif
  );

  par_serial_gen #(.DATA_W(10), .IDLE_WORD(10'h17C)) u_w10 (
    .clk_32f       (clk_32f),
    .reset         (reset),
    .ps_bus        (bus10),
    .data_out_PS   (data_out10),
    .word_start_PS (word_start10),
    .idle_out_PS   (idle_out10)
`ifdef PS_IDLE_CNT_EN
    ,
    .idle_count_PS (idle_cnt10)
`endif
  );

  typedef struct packed {
    logic b;
    logic ws;
    logic idle;
  } exp_t;

  exp_t        exp_q[$];
  int          m_cnt   = 0;
  bit          m_first = 1'b1;
  bit          m_full  = 1'b0;
  logic [7:0]  m_buf   = '0;
  int          m_icnt  = 0;
  int          k10     = 0;
  bit          last_xfer;
  logic [9:0]  pat10   = 10'h17C;
  int          n_cmp   = 0;
  int          n_err   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check ready, advance the model, check outputs.
  task automatic cycle(input bit r, input bit v, input logic [7:0] d);
    bit         load, rdy, sel;
    logic [7:0] word;
    exp_t       e;
    int         p10;
    @(negedge clk_32f);
    reset           = r;
    bus.valid_in_PS = v;
    bus.data_in_PS  = d;
    #1;
    load = m_first || (m_cnt == W - 1);
    rdy  = !r && (!m_full || load);
    check_val("ready", bus.ready_out_PS, rdy);
    last_xfer = v && rdy;
    if (r) begin
      m_cnt   = 0;
      m_first = 1'b1;
      m_full  = 1'b0;
      m_icnt  = 0;
      exp_q.delete();
    end else if (load) begin
      sel = 1'b0;
      if (m_full) word = m_buf;
      else if (last_xfer) word = d;
      else begin
        word = 8'hBC;
        sel  = 1'b1;
      end
      for (int k = W - 1; k >= 0; k--) begin
        e.b    = word[k];
        e.ws   = (k == W - 1);
        e.idle = sel;
        exp_q.push_back(e);
      end
      if (sel && m_icnt < 16'hFFFF) m_icnt++;
      if (m_full && last_xfer) m_buf = d;
      m_full  = m_full && last_xfer;
      m_cnt   = 0;
      m_first = 1'b0;
    end else begin
      if (last_xfer) begin
        m_full = 1'b1;
        m_buf  = d;
      end
      m_cnt++;
    end
    if (last_xfer) $display("xfer data=%02h @%0t", d, $time);
    @(posedge clk_32f);
    #1;
    if (r) begin
      check_val("rst_data", data_out, 0);
      check_val("rst_ws", word_start, 0);
      check_val("rst_idle", idle_out, 0);
      check_val("rst_data10", data_out10, 0);
      k10 = 0;
    end else begin
      if (exp_q.size() == 0) begin
        check_val("q_size", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check_val("data", data_out, e.b);
        check_val("ws", word_start, e.ws);
        check_val("idle", idle_out, e.idle);
      end
      p10 = k10 % 10;
      check_val("data10", data_out10, pat10[9 - p10]);
      check_val("ws10", word_start10, (p10 == 0));
      check_val("idle10", idle_out10, 1);
      k10++;
    end
`ifdef PS_IDLE_CNT_EN
    check_val("idle_cnt", idle_cnt, m_icnt);
`endif
  endtask

  task automatic wait_load();
    for (int i = 0; i < 16; i++) begin
      if (m_first || m_cnt == W - 1) break;
      cycle(0, 0, 8'h00);
    end
  endtask

  task automatic send_word(input logic [7:0] d);
    bit acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      cycle(0, 1, d);
      acc = last_xfer;
    end
    if (!acc) check_val("send_timeout", acc, 1);
  endtask

  initial begin
    bus.valid_in_PS   = 1'b0;
    bus.data_in_PS    = '0;
    bus10.valid_in_PS = 1'b0;
    bus10.data_in_PS  = '0;

    repeat (3) cycle(1, 0, 8'h00);
    repeat (24) cycle(0, 0, 8'h00);

    wait_load();
    send_word(8'hA5);
    repeat (12) cycle(0, 0, 8'h00);

    wait_load();
    send_word(8'h01);
    send_word(8'h02);
    send_word(8'h03);
    repeat (30) cycle(0, 0, 8'h00);

    wait_load();
    send_word(8'hF0);
    send_word(8'h0F);
    repeat (3) cycle(0, 0, 8'h00);
    repeat (2) cycle(1, 0, 8'h00);
    repeat (20) cycle(0, 0, 8'h00);

    for (int i = 0; i < 300; i++) begin
      cycle(0, bit'($urandom_range(0, 1)), 8'($urandom));
    end
    repeat (10) cycle(0, 0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
